// File: rtl/r4mdc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : r4mdc_pkg
// Brief   : Shared types, bank-state encoding and base-4 digit reversal for
//           the radix-4 MDC output reorder buffer.
// Revision: 1.0
// ============================================================================
package r4mdc_pkg;

    typedef logic [1:0] bank_state_t;

    localparam bank_state_t FREE    = 2'd0;
    localparam bank_state_t WRITING = 2'd1;
    localparam bank_state_t FULL    = 2'd2;
    localparam bank_state_t READING = 2'd3;

    // Reverses the order of the log4n two-bit digits of p.
    function automatic logic [31:0] digrev(input logic [31:0] p, input int log4n);
        logic [31:0] r;
        r = '0;
        for (int d = 0; d < log4n; d++) begin
            r[2*d +: 2] = p[2*(log4n-1-d) +: 2];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r4mdc_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module  : r4mdc_pingpong_ram
// Brief   : Two N-entry banks of packed complex samples; one write port and
//           one registered read port. Bank select is the address MSB.
// Revision: 1.0
// ============================================================================
module r4mdc_pingpong_ram #(
    parameter int WL = 16,
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW:0]       i_waddr,
    input  logic [2*WL-1:0]   i_wdata,
    input  logic              i_re,
    input  logic [AW:0]       i_raddr,
    output logic [2*WL-1:0]   o_rdata
);

    logic [2*WL-1:0] r_mem [0:2*N-1];
    logic [2*WL-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register doubles as the output holding register, so it only
    // loads when a read is issued and otherwise holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/r4mdc_output_reorder.sv
`default_nettype none
// ============================================================================
// Module  : r4mdc_output_reorder
// Brief   : Ping-pong reorder buffer turning digit-reversed FFT frames into
//           natural-order frames on a valid/ready output.
// Revision: 1.0
// ============================================================================
module r4mdc_output_reorder
    import r4mdc_pkg::*;
#(
    parameter int WL    = 16,
    parameter int N     = 16,
    parameter int LOG4N = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_start,
    input  logic [WL-1:0] in_r,
    input  logic [WL-1:0] in_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_r,
    output logic [WL-1:0] out_i,
    output logic          out_last,
    output logic          overflow,
    output logic          frame_err
);

    localparam int            c_aw   = 2 * LOG4N;
    localparam logic [c_aw-1:0] c_last = c_aw'(N - 1);

    bank_state_t       r_bank_st  [2];
    bank_state_t       w_bank_nxt [2];
    logic [1:0]        w_avail;
    logic [1:0]        w_full;
    logic [1:0]        w_release;

    logic              r_wr_active;
    logic [c_aw-1:0]   r_wr_cnt;
    logic              r_wr_bank;
    logic              r_rd_busy;
    logic [c_aw-1:0]   r_rd_cnt;
    logic              r_rd_bank;
    logic              r_oldest;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_out_bank;
    logic              r_overflow;
    logic              r_frame_err;

    logic              w_xfer;
    logic              w_discard;
    logic              w_claim_ok;
    logic              w_claim_bank;
    logic              w_ovf;
    logic              w_we;
    logic [c_aw-1:0]   w_wr_pos;
    logic              w_wr_bank;
    logic              w_wr_done;
    logic [c_aw-1:0]   w_wr_addr;
    logic              w_rd_en;
    logic              w_rd_pick;
    logic              w_rd_start;
    logic              w_rd_go;
    logic              w_rd_bank;
    logic [c_aw-1:0]   w_rd_pos;
    logic [2*WL-1:0]   w_rdata;

    assign w_xfer       = r_out_valid && out_ready;
    assign w_discard    = in_start && r_wr_active;
    assign w_claim_ok   = in_start && (|w_avail);
    assign w_claim_bank = !w_avail[0];
    assign w_ovf        = in_start && !(|w_avail);

    assign w_we      = w_claim_ok || (r_wr_active && !in_start);
    assign w_wr_pos  = in_start ? '0 : r_wr_cnt;
    assign w_wr_bank = in_start ? w_claim_bank : r_wr_bank;
    assign w_wr_done = w_we && (w_wr_pos == c_last);
    assign w_wr_addr = c_aw'(digrev(32'(w_wr_pos), LOG4N));

    assign w_rd_en    = !r_out_valid || out_ready;
    assign w_rd_pick  = w_full[r_oldest] ? r_oldest : !r_oldest;
    assign w_rd_start = w_rd_en && !r_rd_busy && (|w_full);
    assign w_rd_go    = w_rd_start || (w_rd_en && r_rd_busy);
    assign w_rd_bank  = r_rd_busy ? r_rd_bank : w_rd_pick;
    assign w_rd_pos   = r_rd_busy ? r_rd_cnt : '0;

    // Bank status flags. A bank whose last sample transfers this cycle, or
    // whose partial frame is being discarded, is immediately claimable.
    always_comb begin
        w_full    = '0;
        w_release = '0;
        w_avail   = '0;
        for (int b = 0; b < 2; b++) begin
            w_full[b]    = (r_bank_st[b] == FULL);
            w_release[b] = w_xfer && r_out_last && (r_out_bank == 1'(b));
            w_avail[b]   = (r_bank_st[b] == FREE) || w_release[b] ||
                           (w_discard && (r_wr_bank == 1'(b)));
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_nxt[b] = r_bank_st[b];
            case (r_bank_st[b])
                FREE: begin
                    if (w_claim_ok && (w_claim_bank == 1'(b))) w_bank_nxt[b] = WRITING;
                end
                WRITING: begin
                    if (w_discard && (r_wr_bank == 1'(b))) begin
                        w_bank_nxt[b] = (w_claim_ok && (w_claim_bank == 1'(b))) ? WRITING : FREE;
                    end else if (w_wr_done && (w_wr_bank == 1'(b))) begin
                        w_bank_nxt[b] = FULL;
                    end
                end
                FULL: begin
                    if (w_rd_start && (w_rd_pick == 1'(b))) w_bank_nxt[b] = READING;
                end
                READING: begin
                    if (w_release[b]) begin
                        w_bank_nxt[b] = (w_claim_ok && (w_claim_bank == 1'(b))) ? WRITING : FREE;
                    end
                end
                default: w_bank_nxt[b] = FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            r_bank_st[b] <= rst ? FREE : w_bank_nxt[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_active <= 1'b0;
            r_wr_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_oldest    <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_ovf;
            r_frame_err <= w_discard;
            if (w_claim_ok) begin
                r_wr_active <= 1'b1;
                r_wr_cnt    <= c_aw'(1);
                r_wr_bank   <= w_claim_bank;
            end else if (r_wr_active) begin
                if (r_wr_cnt == c_last) begin
                    r_wr_active <= 1'b0;
                    r_wr_cnt    <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            // Drain order follows fill order: a newly full bank is oldest
            // only if the other bank is not still waiting to be read.
            if (w_wr_done && (w_bank_nxt[!w_wr_bank] != FULL)) begin
                r_oldest <= w_wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_busy   <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_bank   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_bank  <= 1'b0;
        end else if (w_rd_go) begin
            r_rd_bank   <= w_rd_bank;
            r_out_valid <= 1'b1;
            r_out_last  <= (w_rd_pos == c_last);
            r_out_bank  <= w_rd_bank;
            if (w_rd_pos == c_last) begin
                r_rd_busy <= 1'b0;
                r_rd_cnt  <= '0;
            end else begin
                r_rd_busy <= 1'b1;
                r_rd_cnt  <= w_rd_pos + 1'b1;
            end
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    r4mdc_pingpong_ram #(
        .WL (WL),
        .N  (N),
        .AW (c_aw)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr ({w_wr_bank, w_wr_addr}),
        .i_wdata ({in_r, in_i}),
        .i_re    (w_rd_go),
        .i_raddr ({w_rd_bank, w_rd_pos}),
        .o_rdata (w_rdata)
    );

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_r     = w_rdata[2*WL-1:WL];
    assign out_i     = w_rdata[WL-1:0];
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_r4mdc_output_reorder.sv
`default_nettype none
// ============================================================================
// Module  : tb_r4mdc_output_reorder
// Brief   : Directed scoreboard bench for the radix-4 MDC output reorder.
// Revision: 1.0
// ============================================================================
module tb_r4mdc_output_reorder;

    localparam int WL = 16;
    localparam int N  = 16;

    typedef struct packed {
        logic [WL-1:0] r;
        logic [WL-1:0] i;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_start;
    logic [WL-1:0] in_r;
    logic [WL-1:0] in_i;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_r;
    logic [WL-1:0] out_i;
    logic          out_last;
    logic          overflow;
    logic          frame_err;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    bit            exp_ovf = 0;
    bit            exp_ferr = 0;
    bit            hold_vld = 0;
    logic [WL-1:0] hold_r;
    logic [WL-1:0] hold_i;
    logic          hold_last;
    bit            chk_contig = 0;
    bit            have_prev = 0;
    int            last_xfer = 0;
    bit            first_seen = 0;
    int            first_out = 0;
    int            t_start = 0;

    always #5 clk = ~clk;

    r4mdc_output_reorder #(.WL(WL), .N(N), .LOG4N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_last  (out_last),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected natural-order frame: bin a holds input position (a%4)*4 + a/4.
    task automatic push_frame(input int tag);
        exp_t e;
        logic [WL-1:0] v;
        for (int a = 0; a < N; a++) begin
            v      = WL'(tag * 16 + (a % 4) * 4 + a / 4);
            e.r    = v;
            e.i    = -v;
            e.last = (a == N - 1);
            q.push_back(e);
        end
    endtask

    task automatic step(input bit st, input logic [WL-1:0] r, input logic [WL-1:0] im,
                        input bit e_ovf, input bit e_ferr);
        exp_t e;
        @(negedge clk);
        in_start = st;
        in_r     = r;
        in_i     = im;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        endcase
        check("overflow", overflow, exp_ovf);
        check("frame_err", frame_err, exp_ferr);
        if (hold_vld) begin
            check("hold_valid", out_valid, 1);
            check("hold_r", out_r, hold_r);
            check("hold_i", out_i, hold_i);
            check("hold_last", out_last, hold_last);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_r", out_r, e.r);
                check("out_i", out_i, e.i);
                check("out_last", out_last, e.last);
            end
            if (!first_seen) begin
                first_seen = 1;
                first_out  = cyc;
            end
            if (chk_contig && have_prev) check("contig", cyc - last_xfer, 1);
            have_prev = 1;
            last_xfer = cyc;
        end
        hold_vld  = out_valid && !out_ready;
        hold_r    = out_r;
        hold_i    = out_i;
        hold_last = out_last;
        exp_ovf   = e_ovf;
        exp_ferr  = e_ferr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, WL'($urandom), WL'($urandom), 0, 0);
    endtask

    task automatic send_frame(input int tag, input int nsamp, input bit push,
                              input bit e_ovf, input bit e_ferr);
        logic [WL-1:0] v;
        if (push) push_frame(tag);
        for (int p = 0; p < nsamp; p++) begin
            v = WL'(tag * 16 + p);
            step(p == 0, v, -v, (p == 0) && e_ovf, (p == 0) && e_ferr);
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while (q.size() > 0 && n < maxc) begin
            idle(1);
            n++;
        end
        check(tag, q.size(), 0);
        idle(4);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_start  = 1'b0;
        in_r      = '0;
        in_i      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_r", out_r, 0);
        check("rst_i", out_i, 0);
        check("rst_last", out_last, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b0;

        // Single frame: order, negation, latency of 17 cycles
        rdy_mode   = 0;
        first_seen = 0;
        t_start    = cyc;
        send_frame(1, N, 1, 0, 0);
        drain("drain_single", 100);
        check("first_latency", first_out - t_start, 17);

        // Three back-to-back frames stream without bubbles
        chk_contig = 1;
        have_prev  = 0;
        send_frame(2, N, 1, 0, 0);
        send_frame(3, N, 1, 0, 0);
        send_frame(4, N, 1, 0, 0);
        drain("drain_b2b", 100);
        chk_contig = 0;

        // Output blocked: second frame buffered, third overflows
        rdy_mode = 1;
        send_frame(5, N, 1, 0, 0);
        send_frame(6, N, 1, 0, 0);
        send_frame(7, N, 0, 1, 0);
        idle(5);
        rdy_mode = 0;
        drain("drain_ovf", 100);

        // Stall pattern 1,0,0,1
        rdy_mode = 2;
        send_frame(8, N, 1, 0, 0);
        drain("drain_stall", 200);
        rdy_mode = 0;

        // Restart at position 7 discards the partial frame
        send_frame(9, 7, 0, 0, 0);
        send_frame(10, N, 1, 0, 1);
        drain("drain_ferr", 100);

        // Both banks occupied; new frame starts on the last-sample transfer
        rdy_mode = 1;
        send_frame(11, N, 1, 0, 0);
        send_frame(12, N, 1, 0, 0);
        idle(3);
        rdy_mode = 0;
        n = 0;
        while (!(out_valid && out_last) && n < 40) begin
            idle(1);
            n++;
        end
        check("wait_last", out_valid && out_last, 1);
        send_frame(13, N, 1, 0, 0);
        drain("drain_reclaim", 100);

        // Reset in the middle of draining
        send_frame(14, N, 1, 0, 0);
        idle(6);
        @(negedge clk);
        rst      = 1'b1;
        in_start = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_r", out_r, 0);
        check("mid_rst_i", out_i, 0);
        check("mid_rst_last", out_last, 0);
        rst = 1'b0;
        q.delete();
        hold_vld = 0;
        exp_ovf  = 0;
        exp_ferr = 0;
        idle(3);
        send_frame(15, N, 1, 0, 0);
        drain("drain_after_rst", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/r4mdc_output_reorder.md
Name: r4mdc_output_reorder

Overview:
- Sits downstream of the radix-4 MDC FFT core. Captures each frame of N complex results, which the core emits in base-4 digit-reversed order, and re-emits the frame in natural bin order.
- Uses a two-bank ping-pong buffer, so one frame can be written while the previous frame drains.
- The output uses a valid/ready handshake. The input cannot be stalled.

Parameters:
- WL, 16, bit width of each real and imaginary component.
- N, 16, FFT points per frame; must be a power of 4, with N >= 4.
- LOG4N, 2, number of base-4 digits in an index; equals log4(N).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_start  in  1  one-cycle pulse, coincident with sample 0 of a frame.
- in_r  in  WL  real part of the current input sample.
- in_i  in  WL  imaginary part of the current input sample.
- out_valid  out  1  out_r/out_i/out_last carry a valid sample.
- out_ready  in  1  downstream accepts the sample on this cycle.
- out_r  out  WL  real part of the output sample, natural order.
- out_i  out  WL  imaginary part of the output sample, natural order.
- out_last  out  1  high with sample N-1 of the output frame.
- overflow  out  1  one-cycle pulse: frame dropped because no bank was free.
- frame_err  out  1  one-cycle pulse: in_start arrived mid-frame.

Behaviour:
- Reset: all outputs 0; both banks empty; write and read counters 0; write side idle.
- Input timing: a frame is in_start at cycle t0 plus samples on cycles t0 .. t0+N-1, one per cycle, with no gaps.
- Write addressing: the sample at input position p is written to bank address digrev(p). digrev reverses the LOG4N base-4 digits of p (2-bit fields, MSB digit <-> LSB digit).
- Bank select: in_start claims the lowest-numbered free bank. After writing position N-1 the bank is marked full, effective at cycle t0+N.
- Read side: drains full banks in the order they were filled, addresses 0..N-1 in sequence.
  - Registered read; output holding register with standard valid/ready semantics.
  - out_r, out_i, out_last are stable while out_valid && !out_ready.
  - A sample is transferred when out_valid && out_ready.
- Latency: with out_ready held high, the first out_valid is at t0+N+1 and the N samples appear on consecutive cycles. A full frame following the previous one back-to-back streams out with no bubbles.
- Bank release: a bank becomes free on the cycle its sample N-1 transfers. An in_start on that same cycle may claim that bank.
- Overflow: in_start with no free bank → overflow pulses for 1 cycle at t0+1; the whole frame's samples are ignored. Frames already buffered are unaffected.
- frame_err: in_start while a write is in progress (position 1..N-1).
  - The partial frame is discarded and its bank returned to free.
  - The new in_start is treated as sample 0 of a new frame.
  - frame_err pulses at t0+1.
- Samples arriving with no frame active are ignored.
- Reset mid-operation: buffered data is discarded; reset values apply on the next edge; no out_valid until a new frame completes.
- Arithmetic: pure data movement; no rounding, scaling or sign change; bit-exact passthrough.

Decomposition:
- Shared package (r4mdc_pkg):
  - digrev function, parameterised on LOG4N;
  - bank-state encoding constants: FREE, WRITING, FULL, READING.
- Sub-module: r4mdc_pingpong_ram.
  - Two banks of N x 2*WL.
  - One write port, one registered read port, with bank-select bit as the address MSB.
- Control counters and bank FSMs live in the top.

Test Plan:
- N=16, out_ready=1, one frame where in_r=p, in_i=-p for p=0..15 → output order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 with matching in_i negation. First out_valid exactly 17 cycles after in_start; out_last on value 15.
- Three back-to-back frames with out_ready=1 → 48 contiguous valid outputs, no overflow, each frame correctly reordered.
- out_ready=0 after frame 1; frames 2 and 3 sent → frame 2 buffered, frame 3 → overflow pulse. Then release out_ready → frames 1 and 2 output intact.
- Stall pattern: out_ready toggled 1,0,0,1 → data and out_last held stable while stalled; no sample duplicated or lost.
- in_start at position 7 of a frame → frame_err pulse; the partial frame is never output; the following 16-sample frame is output correctly.
- rst asserted mid-drain → next cycle out_valid=0 and all outputs 0; a fresh frame afterwards is output correctly from bin 0. Also cover: both banks full and in_start on the same cycle as the last-sample transfer → accepted, no overflow.
